// File: rtl/exec_sequencer.sv
// Multi-cycle RV32I control sequencer: accepts one instruction word per handshake,
// walks it through DECODE/EXEC/WB and drives the register-file/ALU datapath controls and PC.
//
// state  | meaning
// IDLE   | ready for a new instruction word
// DECODE | latched word being decoded; controls update on exit
// EXEC   | controls held, ALU settling; BNE resolves pc here
// WB     | regWrite pulse (unless rd==0), pc += 4
module exec_sequencer #(
    parameter int                 A_WIDTH  = 5,
    parameter int                 D_WIDTH  = 32,
    parameter logic [D_WIDTH-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    input  logic               eq,
    output logic               regWrite,
    output logic [2:0]         ALUctrl,
    output logic               ALUsrc,
    output logic [A_WIDTH-1:0] rs1,
    output logic [A_WIDTH-1:0] rs2,
    output logic [A_WIDTH-1:0] rd,
    output logic [D_WIDTH-1:0] ImmOp,
    output logic [D_WIDTH-1:0] pc,
    output logic               illegal
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_WB} state_t;

    localparam logic [D_WIDTH-1:0] PC_STEP = D_WIDTH'(4);

    state_t             state_q;
    logic [31:0]        instr_q;
    logic               is_bne_q;
    logic               regWrite_q;
    logic [2:0]         alu_ctrl_q;
    logic               alu_src_q;
    logic [A_WIDTH-1:0] rs1_q, rs2_q, rd_q;
    logic [D_WIDTH-1:0] imm_q;
    logic [D_WIDTH-1:0] pc_q;
    logic               illegal_q;

    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic               legal_d;
    logic               is_bne_d;
    logic               alu_src_d;
    logic [2:0]         alu_ctrl_d;
    logic [D_WIDTH-1:0] imm_d;

    assign opcode = instr_q[6:0];
    assign funct3 = instr_q[14:12];
    assign funct7 = instr_q[31:25];

    always_comb begin
        legal_d    = 1'b0;
        is_bne_d   = 1'b0;
        alu_src_d  = 1'b0;
        alu_ctrl_d = 3'b000;
        imm_d      = '0;
        if (opcode == 7'b0010011 && funct3 == 3'b000) begin
            legal_d   = 1'b1;
            alu_src_d = 1'b1;
            imm_d     = {{(D_WIDTH-12){instr_q[31]}}, instr_q[31:20]};
        end else if (opcode == 7'b0110011 && funct3 == 3'b000 &&
                     (funct7 == 7'b0000000 || funct7 == 7'b0100000)) begin
            legal_d    = 1'b1;
            alu_ctrl_d = (funct7 == 7'b0100000) ? 3'b001 : 3'b000;
        end else if (opcode == 7'b1100011 && funct3 == 3'b001) begin
            legal_d    = 1'b1;
            is_bne_d   = 1'b1;
            alu_ctrl_d = 3'b001;
            imm_d      = {{(D_WIDTH-13){instr_q[31]}}, instr_q[31], instr_q[7],
                          instr_q[30:25], instr_q[11:8], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            instr_q    <= '0;
            is_bne_q   <= 1'b0;
            regWrite_q <= 1'b0;
            alu_ctrl_q <= 3'b000;
            alu_src_q  <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            imm_q      <= '0;
            pc_q       <= RESET_PC;
            illegal_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (instr_valid) begin
                        instr_q <= instr;
                        state_q <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // An illegal word leaves every datapath control untouched.
                    if (legal_d) begin
                        rs1_q      <= A_WIDTH'(instr_q[19:15]);
                        rs2_q      <= A_WIDTH'(instr_q[24:20]);
                        rd_q       <= A_WIDTH'(instr_q[11:7]);
                        alu_src_q  <= alu_src_d;
                        alu_ctrl_q <= alu_ctrl_d;
                        imm_q      <= imm_d;
                        is_bne_q   <= is_bne_d;
                        state_q    <= S_EXEC;
                    end else begin
                        illegal_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    if (is_bne_q) begin
                        pc_q    <= eq ? (pc_q + PC_STEP) : (pc_q + imm_q);
                        state_q <= S_IDLE;
                    end else begin
                        regWrite_q <= (rd_q != '0);
                        state_q    <= S_WB;
                    end
                end
                S_WB: begin
                    regWrite_q <= 1'b0;
                    pc_q       <= pc_q + PC_STEP;
                    state_q    <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign regWrite    = regWrite_q;
    assign ALUctrl     = alu_ctrl_q;
    assign ALUsrc      = alu_src_q;
    assign rs1         = rs1_q;
    assign rs2         = rs2_q;
    assign rd          = rd_q;
    assign ImmOp       = imm_q;
    assign pc          = pc_q;
    assign illegal     = illegal_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Bench for exec_sequencer: directed test-plan steps, random instruction mix and a
// valid-held stream, all compared against an instruction-level reference model.
module tb_exec_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        eq;
    logic        regWrite;
    logic [2:0]  ALUctrl;
    logic        ALUsrc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] ImmOp;
    logic [31:0] pc;
    logic        illegal;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] mdl_pc;
    logic        mdl_ill;
    logic        mdl_alusrc;
    logic [2:0]  mdl_aluctrl;

    localparam logic [1:0] KIND_ARITH = 2'd0;
    localparam logic [1:0] KIND_BNE   = 2'd1;
    localparam logic [1:0] KIND_ILL   = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        alusrc;
        logic [2:0]  aluctrl;
        logic        has_imm;
        logic [31:0] imm;
    } exp_t;

    exec_sequencer dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .eq(eq), .regWrite(regWrite), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
        .rs1(rs1), .rs2(rs2), .rd(rd), .ImmOp(ImmOp), .pc(pc), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] enc_addi(input logic [4:0] rd_a, input logic [4:0] rs1_a,
                                             input logic [11:0] imm);
        return {imm, rs1_a, 3'b000, rd_a, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd_a,
                                          input logic [4:0] rs1_a, input logic [4:0] rs2_a);
        return {f7, rs2_a, rs1_a, 3'b000, rd_a, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_bne(input logic [4:0] rs1_a, input logic [4:0] rs2_a,
                                            input int off);
        logic [12:0] i;
        i = 13'(off);
        return {i[12], i[10:5], rs2_a, rs1_a, 3'b001, i[4:1], i[11], 7'b1100011};
    endfunction

    // Instruction-level meaning of a word: what the datapath should be told.
    function automatic exp_t model(input logic [31:0] w);
        exp_t m;
        int   v;
        m         = '0;
        m.kind    = KIND_ILL;
        m.rs1     = w[19:15];
        m.rs2     = w[24:20];
        m.rd      = w[11:7];
        if (w[6:0] == 7'b0010011 && w[14:12] == 3'b000) begin
            v = int'(w[31:20]);
            if (v >= 2048) v = v - 4096;
            m.kind = KIND_ARITH; m.alusrc = 1'b1; m.has_imm = 1'b1; m.imm = 32'(v);
        end else if (w[6:0] == 7'b0110011 && w[14:12] == 3'b000 &&
                     (w[31:25] == 7'h00 || w[31:25] == 7'h20)) begin
            m.kind    = KIND_ARITH;
            m.aluctrl = (w[31:25] == 7'h20) ? 3'd1 : 3'd0;
        end else if (w[6:0] == 7'b1100011 && w[14:12] == 3'b001) begin
            v = int'({w[31], w[7], w[30:25], w[11:8]}) * 2;
            if (v >= 4096) v = v - 8192;
            m.kind = KIND_BNE; m.aluctrl = 3'd1; m.has_imm = 1'b1; m.imm = 32'(v);
        end
        return m;
    endfunction

    task automatic check_reset_state(input string tag);
        chk({tag, "_ready"},   32'(instr_ready), 32'd1);
        chk({tag, "_wr"},      32'(regWrite),    32'd0);
        chk({tag, "_aluctrl"}, 32'(ALUctrl),     32'd0);
        chk({tag, "_alusrc"},  32'(ALUsrc),      32'd0);
        chk({tag, "_rs1"},     32'(rs1),         32'd0);
        chk({tag, "_rs2"},     32'(rs2),         32'd0);
        chk({tag, "_rd"},      32'(rd),          32'd0);
        chk({tag, "_imm"},     ImmOp,            32'd0);
        chk({tag, "_pc"},      pc,               32'd0);
        chk({tag, "_illegal"}, 32'(illegal),     32'd0);
    endtask

    // Call at #1 after a rising edge with the sequencer idle.
    task automatic issue(input logic [31:0] w, input logic eq_v);
        exp_t        m;
        logic [31:0] pc0;
        m   = model(w);
        pc0 = mdl_pc;
        chk("ready_idle", 32'(instr_ready), 32'd1);
        instr = w; instr_valid = 1'b1; eq = 1'($urandom);
        @(posedge clk); #1;
        instr_valid = 1'($urandom); instr = $urandom;
        chk("ready_e0", 32'(instr_ready), 32'd0);
        chk("wr_e0", 32'(regWrite), 32'd0);
        @(posedge clk); #1;
        if (m.kind == KIND_ILL) begin
            mdl_ill = 1'b1;
            chk("ill_flag",    32'(illegal),     32'd1);
            chk("ill_pc",      pc,               mdl_pc);
            chk("ill_wr",      32'(regWrite),    32'd0);
            chk("ill_ready",   32'(instr_ready), 32'd1);
            chk("ill_aluctrl", 32'(ALUctrl),     32'(mdl_aluctrl));
            chk("ill_alusrc",  32'(ALUsrc),      32'(mdl_alusrc));
            instr_valid = 1'b0;
            return;
        end
        mdl_alusrc  = m.alusrc;
        mdl_aluctrl = m.aluctrl;
        chk("dec_rs1",     32'(rs1),         32'(m.rs1));
        chk("dec_rs2",     32'(rs2),         32'(m.rs2));
        chk("dec_rd",      32'(rd),          32'(m.rd));
        chk("dec_alusrc",  32'(ALUsrc),      32'(m.alusrc));
        chk("dec_aluctrl", 32'(ALUctrl),     32'(m.aluctrl));
        if (m.has_imm) chk("dec_imm", ImmOp, m.imm);
        chk("dec_illegal", 32'(illegal),     32'(mdl_ill));
        chk("wr_e1",       32'(regWrite),    32'd0);
        chk("ready_e1",    32'(instr_ready), 32'd0);
        eq = eq_v;
        @(posedge clk); #1;
        eq = 1'($urandom);
        if (m.kind == KIND_BNE) begin
            mdl_pc = pc0 + (eq_v ? 32'd4 : m.imm);
            chk("bne_pc",    pc,               mdl_pc);
            chk("bne_wr",    32'(regWrite),    32'd0);
            chk("bne_ready", 32'(instr_ready), 32'd1);
            instr_valid = 1'b0;
            return;
        end
        chk("wb_wr",    32'(regWrite),    32'(m.rd != 5'd0));
        chk("wb_pc",    pc,               pc0);
        chk("wb_ready", 32'(instr_ready), 32'd0);
        @(posedge clk); #1;
        mdl_pc = pc0 + 32'd4;
        chk("done_wr",    32'(regWrite),    32'd0);
        chk("done_pc",    pc,               mdl_pc);
        chk("done_ready", 32'(instr_ready), 32'd1);
        instr_valid = 1'b0;
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] words   [6];
        logic [4:0]  exp_rd  [6];
        logic [31:0] exp_imm [6];
        int          r;
        int          k;
        int          last_acc;
        logic        acc;

        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; eq = 1'b0;
        mdl_pc = 32'd0; mdl_ill = 1'b0; mdl_alusrc = 1'b0; mdl_aluctrl = 3'd0;
        #2;
        check_reset_state("rst");
        #5 rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_state("post_rst");

        issue(32'hFFD00293, 1'b0);
        issue(32'h40838333, 1'b1);
        issue(enc_addi(5'd1, 5'd0, 12'd7), 1'b0);
        issue(enc_addi(5'd2, 5'd1, 12'hFFF), 1'b1);
        chk("pc_before_bne", pc, 32'h10);
        issue(enc_bne(5'd1, 5'd2, -8), 1'b0);
        chk("bne_taken_pc", pc, 32'h08);
        issue(enc_r(7'h00, 5'd3, 5'd1, 5'd2), 1'b0);
        issue(enc_r(7'h20, 5'd4, 5'd3, 5'd1), 1'b1);
        issue(enc_bne(5'd3, 5'd4, -8), 1'b1);
        chk("bne_not_taken_pc", pc, 32'h14);
        issue(enc_addi(5'd0, 5'd0, 12'd1), 1'b0);
        issue(32'hFFFFFFFF, 1'b0);
        issue(enc_r(7'h00, 5'd9, 5'd1, 5'd2), 1'b0);
        chk("illegal_sticky", 32'(illegal), 32'd1);

        for (int i = 0; i < 40; i++) begin
            r = int'($urandom_range(0, 4));
            case (r)
                0:       w = enc_addi(5'($urandom), 5'($urandom), 12'($urandom));
                1:       w = enc_r(7'h00, 5'($urandom), 5'($urandom), 5'($urandom));
                2:       w = enc_r(7'h20, 5'($urandom), 5'($urandom), 5'($urandom));
                3:       w = enc_bne(5'($urandom), 5'($urandom), (int'($urandom_range(0, 4095)) - 2048) * 2);
                default: w = $urandom;
            endcase
            issue(w, 1'($urandom));
        end

        instr = enc_r(7'h00, 5'd9, 5'd1, 5'd2); instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort_wr_before", 32'(regWrite), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_wr",      32'(regWrite),    32'd0);
        chk("abort_pc",      pc,               32'd0);
        chk("abort_ready",   32'(instr_ready), 32'd1);
        chk("abort_illegal", 32'(illegal),     32'd0);
        mdl_pc = 32'd0; mdl_ill = 1'b0; mdl_alusrc = 1'b0; mdl_aluctrl = 3'd0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        issue(enc_bne(5'd1, 5'd2, -4), 1'b0);
        chk("pre_wrap_pc", pc, 32'hFFFFFFFC);

        for (int i = 0; i < 6; i++) begin
            exp_rd[i]  = 5'(i + 1);
            exp_imm[i] = 32'(i * 3 - 5);
            words[i]   = enc_addi(exp_rd[i], 5'(i), 12'(i * 3 - 5));
        end
        k = 0; last_acc = -10;
        instr = words[0]; instr_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            acc = instr_ready;
            @(posedge clk); #1;
            if (acc) begin
                if (last_acc >= 0) chk("stream_spacing", 32'(c - last_acc), 32'd4);
                last_acc = c;
                k++;
                instr = (k < 6) ? words[k] : $urandom;
            end else if (c == last_acc + 1) begin
                chk("stream_rd",  32'(rd), 32'(exp_rd[k-1]));
                chk("stream_imm", ImmOp,   exp_imm[k-1]);
            end
            if (c == 3) chk("wrap_pc", pc, 32'h0);
        end
        instr_valid = 1'b0;
        mdl_pc = mdl_pc + 32'd24;
        chk("stream_accepts", 32'(k), 32'd6);
        chk("stream_pc", pc, mdl_pc);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
